// File: rtl/cla_arb_pkg.sv
// Shared constants, slot state encoding and ID-width helper for the
// carry-lookahead adder share arbiter.
package cla_arb_pkg;

   localparam int DEFAULT_WIDTH = 44;
   localparam int DEFAULT_N_REQ = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   // Requester index width; a single requester still gets one ID bit.
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cla_44bit.sv
// Combinational carry-lookahead adder. Four-bit lookahead groups, with the
// group carries chained through group generate/propagate terms.
// Widths that are not a multiple of four are zero-padded internally.
module cla_44bit #(
   parameter int WIDTH = 44
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NG = (WIDTH + 3) / 4;
   localparam int PW = NG * 4;

   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_ext;
   logic [PW-1:0] g;
   logic [PW-1:0] p;
   logic [PW:0]   c;
   logic [NG:0]   gc;
   logic [NG-1:0] gg;
   logic [NG-1:0] gp;

   // Bit and group generate/propagate, group carry chain, in-group carries.
   always_comb begin
      a_ext = '0;
      b_ext = '0;
      a_ext[WIDTH-1:0] = a;
      b_ext[WIDTH-1:0] = b;
      g  = a_ext & b_ext;
      p  = a_ext ^ b_ext;
      gg = '0;
      gp = '0;
      gc = '0;
      c  = '0;
      gc[0] = cin;
      for (int j = 0; j < NG; j++) begin
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
         gp[j] = &p[4*j +: 4];
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      end
      for (int j = 0; j < NG; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1]
                  | (p[4*j+1] & g[4*j])
                  | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2]
                  | (p[4*j+2] & g[4*j+1])
                  | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
      c[PW] = gc[NG];
   end

   assign sum  = p[WIDTH-1:0] ^ c[WIDTH-1:0];
   assign cout = c[WIDTH];

endmodule

// File: rtl/cla_rr_pick.sv
// Combinational round-robin picker: first set request at or after
// last_ptr+1, wrapping modulo N_REQ.
module cla_rr_pick #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any
);

   int idx;

   // Walk the requesters in priority order and latch the first hit.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = (int'(last_ptr) + off) % N_REQ;
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cla_share_arbiter.sv
// Round-robin share of one carry-lookahead adder among N_REQ requesters,
// with a single registered response slot (valid/ready, tagged by ID).
// Optional stall counter output enabled by defining CLA_ARB_STALL_CNT_EN.
//
//   state | meaning
//   EMPTY | no result held; any winning request may be accepted
//   FULL  | result held on o_rsp_*; refill only when drained same cycle
module cla_share_arbiter
   import cla_arb_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   parameter  int N_REQ = DEFAULT_N_REQ,
   localparam int ID_W  = id_width(N_REQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req_valid,
   output logic [N_REQ-1:0]       o_req_ready,
   input  logic [N_REQ*WIDTH-1:0] i_req_add1,
   input  logic [N_REQ*WIDTH-1:0] i_req_add2,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [WIDTH:0]         o_rsp_result,
   output logic [ID_W-1:0]        o_rsp_id
`ifdef CLA_ARB_STALL_CNT_EN
   ,
   output logic [15:0]            o_stall_cnt
`endif
);

   slot_state_t      state;
   slot_state_t      state_next;
   logic [ID_W-1:0]  last_ptr;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             any_req;
   logic             can_accept;
   logic             accept;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] sum;
   logic             cout;

   cla_rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req       (i_req_valid),
      .last_ptr  (last_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any_req)
   );

   // Operand mux from the current winner into the single shared adder.
   always_comb begin
      add_a = i_req_add1[int'(grant_idx)*WIDTH +: WIDTH];
      add_b = i_req_add2[int'(grant_idx)*WIDTH +: WIDTH];
   end

   cla_44bit #(
      .WIDTH (WIDTH)
   ) u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // Handshake: ready only to the winner, only when the slot can take it,
   // and never while reset is asserted.
   always_comb begin
      can_accept  = ((state == EMPTY) | i_rsp_ready) & ~i_rst;
      o_req_ready = can_accept ? grant : '0;
      accept      = can_accept & any_req;
   end

   // Slot state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= EMPTY;
      else       state <= state_next;
   end

   // Slot next state: fill on accept, drain on handshake, hold otherwise.
   always_comb begin
      state_next = state;
      if (accept)                         state_next = FULL;
      else if ((state == FULL) && i_rsp_ready) state_next = EMPTY;
   end

   assign o_rsp_valid = (state == FULL);

   // Result, tag and fairness pointer all move together on accept.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_result <= '0;
         o_rsp_id     <= '0;
         last_ptr     <= ID_W'(N_REQ - 1);
      end else if (accept) begin
         o_rsp_result <= {cout, sum};
         o_rsp_id     <= grant_idx;
         last_ptr     <= grant_idx;
      end
   end

`ifdef CLA_ARB_STALL_CNT_EN
   // Saturating count of cycles the consumer held off a valid response.
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_stall_cnt <= '0;
      else if (o_rsp_valid && !i_rsp_ready && (o_stall_cnt != 16'hFFFF))
         o_stall_cnt <= o_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: doc/cla_share_arbiter.md
# cla_share_arbiter

- Shares one combinational carry-lookahead adder (`cla_44bit`, WIDTH-overridden) among N_REQ requesters.
- Arbitration is round-robin.
- Each accepted request's sum is captured in a single registered response slot, tagged with the requester ID and a valid/ready handshake.
- Sits between the operand-producing units and the adder, so only one adder instance exists per cluster.

## Interface
- `WIDTH`, 44, operand width in bits.
- `N_REQ`, 4, number of requesters (2..16).
- `ID_W`, `$clog2(N_REQ)`, requester ID width (derived, not overridden).

- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  N_REQ  per-requester request valid.
- `o_req_ready`  out  N_REQ  per-requester accept; at most one bit high per cycle.
- `i_req_add1`  in  N_REQ*WIDTH  packed operand A; requester k at bits [k*WIDTH +: WIDTH].
- `i_req_add2`  in  N_REQ*WIDTH  packed operand B, same packing.
- `o_rsp_valid`  out  1  response slot holds a result.
- `i_rsp_ready`  in  1  consumer accepts the response.
- `o_rsp_result`  out  WIDTH+1  {carry-out, sum}.
- `o_rsp_id`  out  ID_W  index of the requester that produced the result.

## Operation
- Response slot FSM has two states, EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on `o_rsp_valid & i_rsp_ready` with no new accept.
  - FULL -> FULL on simultaneous drain and accept (slot overwritten with the new result).
- Slot can accept when `EMPTY | i_rsp_ready`.
- Round-robin grant:
  - Search starts at `last_ptr+1` (mod N_REQ) and takes the first requester with `i_req_valid` set.
  - `o_req_ready[g]` = 1 only for that winner g, and only while the slot can accept.
  - All other ready bits are 0.
- Accept = `i_req_valid[g] & o_req_ready[g]`.
- On accept:
  - Adder inputs are muxed from requester g.
  - `o_rsp_result` <= adder output, full WIDTH+1 bits, carry-out in MSB, no truncation.
  - `o_rsp_id` <= g.
  - `last_ptr` <= g.
- `last_ptr` changes only on accept. A requester that loses arbitration keeps priority order unchanged.
- Request-side rule: a requester must hold valid and operands stable until accepted. `i_req_valid` must not depend on `o_req_ready`.
- Response-side rule: `o_rsp_valid`, `o_rsp_result` and `o_rsp_id` stay stable while valid and not ready.
- `o_req_ready` depends combinationally on `i_req_valid` and `i_rsp_ready`. This is the only combinational input-to-output path. Outputs `o_rsp_*` are registered.

## Timing
- Reset (synchronous, `i_rst`=1 at an edge):
  - `o_rsp_valid`=0, `o_rsp_result`=0, `o_rsp_id`=0, state EMPTY.
  - `last_ptr`=N_REQ-1, so requester 0 has first priority.
  - `o_req_ready` = 0 in every cycle `i_rst` is high.
- Reset mid-operation discards a held result without a handshake.
- Latency: accept at edge t, so `o_rsp_valid`=1 in the cycle after edge t.
- Throughput: one result per cycle when `i_rsp_ready` is held high.
- Backpressure: while FULL and `i_rsp_ready`=0, all `o_req_ready`=0 and no pointer change.
- No valid requests: no accept. FULL drains to EMPTY on ready.
- Single persistent requester: granted every cycle, with no bubbles.
- All N_REQ valid continuously: grants cycle 0,1,…,N_REQ-1,0 (wrap), each requester served within N_REQ accepts.

## Configuration
- `CLA_ARB_STALL_CNT_EN` defined:
  - Adds output `o_stall_cnt` [15:0].
  - Counts cycles with `o_rsp_valid & ~i_rsp_ready`.
  - Saturates at 16'hFFFF and clears on reset.
- Not defined: port and counter absent. All other behaviour is identical.

## Structure
- Package `cla_arb_pkg`:
  - Default WIDTH and N_REQ constants.
  - `slot_state_t` enum {EMPTY, FULL}.
  - ID-width helper function.
- Sub-module `cla_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, `last_ptr`.
  - Outputs: one-hot grant, grant index, `any`.
- Adder: one `cla_44bit` instance with WIDTH override, fed by the grant mux.
- Top holds the slot register, FSM, pointer and optional counter.

## Test plan
- Reset, then requester 2 sends A=44'h0FF_FFFF_FFFF, B=1 with `i_rsp_ready`=1 -> next cycle `o_rsp_valid`=1, result=45'h100_0000_0000, id=2.
- Carry-out: requester 0 sends A=B=44'hFFF_FFFF_FFFF -> result=45'h1FFF_FFFF_FFFE (MSB=1), id=0.
- All 4 valid continuously, ready=1 -> ids 0,1,2,3,0,1 on consecutive cycles with no idle cycles.
- Slot FULL, `i_rsp_ready`=0 for 5 cycles with requesters 1 and 3 valid -> `o_req_ready`=0, response held stable. On ready: id=1 is accepted that same cycle and drains, and requester 3 is granted the following cycle.
- `i_rst` asserted while FULL with requester 2 valid -> next cycle `o_rsp_valid`=0. After release, requester 0 wins over 2 when both are valid.
- With `CLA_ARB_STALL_CNT_EN`: hold ready low for 7 FULL cycles -> `o_stall_cnt`=7. Force 70000 stall cycles -> counter stays at 16'hFFFF.
